adma_desc_pusher: RTL and testbench
===================================

ADMA_DESC_PUSHER -- requirements
Module: adma_desc_pusher

Interface
REQ-001 SHALL have parameters: DMA_BASE_ADDR 32'h8000_0000 (CSR base); DMA_CHN_NUM 4 (channels); DMA_LENGTH_W 16 (length/stride width); DMA_DESC_DEPTH 4 (descriptors per channel); M_DATA_W 32; M_ADDR_W 32; MST_ID_W 5; PUSH_ID 0 (AXI ID for all transactions).
REQ-002 SHALL have one clock and a synchronous, active-high reset: aclk in 1 (clock); areset in 1 (synchronous active-high reset).
REQ-003 SHALL have command ports: cmd_vld_i in 1; cmd_rdy_o out 1; cmd_chn_i in $clog2(DMA_CHN_NUM); cmd_src_addr_i in 32; cmd_dst_addr_i in 32; cmd_xlen_i, cmd_ylen_i, cmd_src_strd_i, cmd_dst_strd_i in DMA_LENGTH_W each.
REQ-004 SHALL have response ports: rsp_vld_o out 1; rsp_rdy_i in 1; rsp_err_o out 1; rsp_xfer_id_o out $clog2(DMA_DESC_DEPTH).
REQ-005 SHALL have AXI4 master ports: m_awid_o, m_awaddr_o, m_awlen_o(8), m_awvalid_o, m_awready_i; m_wdata_o, m_wlast_o, m_wvalid_o, m_wready_i; m_bid_i, m_bresp_i(2), m_bvalid_i, m_bready_o; m_arid_o, m_araddr_o, m_arlen_o(8), m_arvalid_o, m_arready_i; m_rid_i, m_rdata_i, m_rresp_i(2), m_rlast_i, m_rvalid_i, m_rready_o.

Function
REQ-006 SHALL accept a command on cmd_vld_i&&cmd_rdy_o; cmd_rdy_o=1 only in IDLE; all command fields are registered on acceptance.
REQ-007 SHALL use states IDLE -> WR (issue write) -> WB (await B) -> {WR next reg | PUSH_WR | RD} -> RD_AR -> RD_R -> RSP -> IDLE.
REQ-008 SHALL write, in order, six descriptor words at DMA_BASE_ADDR + ((chn*16 + k) << 2) for k = 9..14: src_addr, dst_addr, xlen, ylen, src_strd, dst_strd (zero-extended to 32 bits).
REQ-009 SHALL then write 32'h1 to the push register at DMA_BASE_ADDR + 32'h1000 + ((chn*16) << 2).
REQ-010 SHALL then read xfer_id at DMA_BASE_ADDR + 32'h2000 + ((chn*16 + 1) << 2), capturing m_rdata_i[$clog2(DMA_DESC_DEPTH)-1:0] into rsp_xfer_id_o.
REQ-011 SHALL issue only single-beat transactions: awlen=arlen=0, wlast=1, id=PUSH_ID; at most one transaction outstanding.
REQ-012 SHALL in WR assert awvalid and wvalid together in the first WR cycle; each deasserts independently after its own handshake; WB is entered once both handshakes have completed (same cycle or different cycles).
REQ-013 SHALL hold address/data stable while valid is asserted and not accepted.
REQ-014 SHALL assert m_bready_o only in WB and m_rready_o only in RD_R.
REQ-015 SHALL on bresp!=0 or rresp!=0 skip remaining steps, go to RSP with rsp_err_o=1 and rsp_xfer_id_o=0.
REQ-016 SHALL hold rsp_vld_o=1 in RSP until rsp_rdy_i; return to IDLE the cycle after the handshake; a new command is not accepted in the handshake cycle.
REQ-017 SHALL keep a 3-bit step counter 0..7 (0-5 descriptors, 6 push, 7 read) reset on command acceptance.
REQ-018 SHALL ignore m_bid_i/m_rid_i values and m_rlast_i (single beat).
REQ-019 SHALL give minimum command-to-response latency of 2*7 (write) + 2 (read) + 1 = 17 cycles with all readies tied high.

Reset
REQ-020 SHALL, while areset=1 at a rising aclk edge, enter IDLE with all valid/ready outputs 0 except cmd_rdy_o=1, rsp_err_o=0, rsp_xfer_id_o=0, counter 0.
REQ-021 SHALL abandon any in-flight transaction on reset mid-operation without waiting for B/R; the bench drops slave state simultaneously.

Verification
REQ-022 Nominal: chn=2, src=0x1000_0000, dst=0x2000_0000, xlen=0x40; slave returns xfer_id=3 -> writes at 0x8000_00A4..0x8000_00B8, push at 0x8000_1080, read at 0x8000_2084, rsp_xfer_id_o=3, rsp_err_o=0.
REQ-023 Staggered handshakes: awready delayed 3 cycles, wready immediate -> single B wait, data unchanged, no duplicate writes.
REQ-024 Error: bresp=2'b10 on third write -> no further AW/AR, rsp_vld_o with rsp_err_o=1, rsp_xfer_id_o=0.
REQ-025 Backpressure: rsp_rdy_i low 5 cycles -> rsp_vld_o and fields stable, cmd_rdy_o=0 throughout.
REQ-026 Reset mid-WB -> next cycle cmd_rdy_o=1, all AXI valids 0; following command completes normally.

Source files
------------

// File: rtl/adma_desc_pusher.sv
// Programs one DMA channel's descriptor registers over AXI4, pushes the
// descriptor, then reads back the assigned transfer id.
module adma_desc_pusher #(
    parameter logic [31:0] DMA_BASE_ADDR  = 32'h8000_0000,
    parameter int          DMA_CHN_NUM    = 4,
    parameter int          DMA_LENGTH_W   = 16,
    parameter int          DMA_DESC_DEPTH = 4,
    parameter int          M_DATA_W       = 32,
    parameter int          M_ADDR_W       = 32,
    parameter int          MST_ID_W       = 5,
    parameter int          PUSH_ID        = 0
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              cmd_vld_i,
    output logic                              cmd_rdy_o,
    input  logic [$clog2(DMA_CHN_NUM)-1:0]    cmd_chn_i,
    input  logic [31:0]                       cmd_src_addr_i,
    input  logic [31:0]                       cmd_dst_addr_i,
    input  logic [DMA_LENGTH_W-1:0]           cmd_xlen_i,
    input  logic [DMA_LENGTH_W-1:0]           cmd_ylen_i,
    input  logic [DMA_LENGTH_W-1:0]           cmd_src_strd_i,
    input  logic [DMA_LENGTH_W-1:0]           cmd_dst_strd_i,
    output logic                              rsp_vld_o,
    input  logic                              rsp_rdy_i,
    output logic                              rsp_err_o,
    output logic [$clog2(DMA_DESC_DEPTH)-1:0] rsp_xfer_id_o,
    output logic [MST_ID_W-1:0]               m_awid_o,
    output logic [M_ADDR_W-1:0]               m_awaddr_o,
    output logic [7:0]                        m_awlen_o,
    output logic                              m_awvalid_o,
    input  logic                              m_awready_i,
    output logic [M_DATA_W-1:0]               m_wdata_o,
    output logic                              m_wlast_o,
    output logic                              m_wvalid_o,
    input  logic                              m_wready_i,
    input  logic [MST_ID_W-1:0]               m_bid_i,
    input  logic [1:0]                        m_bresp_i,
    input  logic                              m_bvalid_i,
    output logic                              m_bready_o,
    output logic [MST_ID_W-1:0]               m_arid_o,
    output logic [M_ADDR_W-1:0]               m_araddr_o,
    output logic [7:0]                        m_arlen_o,
    output logic                              m_arvalid_o,
    input  logic                              m_arready_i,
    input  logic [MST_ID_W-1:0]               m_rid_i,
    input  logic [M_DATA_W-1:0]               m_rdata_i,
    input  logic [1:0]                        m_rresp_i,
    input  logic                              m_rlast_i,
    input  logic                              m_rvalid_i,
    output logic                              m_rready_o
);

    localparam int CHN_W = $clog2(DMA_CHN_NUM);
    localparam int ID_W  = $clog2(DMA_DESC_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WB, S_PUSH_WR, S_RD_AR, S_RD_R, S_RSP
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              step_q, step_d;
    logic [CHN_W-1:0]        chn_q, chn_d;
    logic [31:0]             src_q, src_d, dst_q, dst_d;
    logic [DMA_LENGTH_W-1:0] xlen_q, xlen_d, ylen_q, ylen_d;
    logic [DMA_LENGTH_W-1:0] sstr_q, sstr_d, dstr_q, dstr_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                    err_q, err_d;
    logic [ID_W-1:0]         xid_q, xid_d;

    logic                    wr_st, aw_hs, w_hs;
    logic [M_ADDR_W-1:0]     chn_off;

    logic unused_w;
    assign unused_w = ^{m_bid_i, m_rid_i, m_rlast_i, m_rdata_i[M_DATA_W-1:ID_W]};

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            chn_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            xlen_q    <= '0;
            ylen_q    <= '0;
            sstr_q    <= '0;
            dstr_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            xid_q     <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            chn_q     <= chn_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            xlen_q    <= xlen_d;
            ylen_q    <= ylen_d;
            sstr_q    <= sstr_d;
            dstr_q    <= dstr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            xid_q     <= xid_d;
        end
    end

    assign wr_st = (state_q == S_WR) || (state_q == S_PUSH_WR);
    assign aw_hs = m_awvalid_o && m_awready_i;
    assign w_hs  = m_wvalid_o && m_wready_i;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        chn_d     = chn_q;
        src_d     = src_q;
        dst_d     = dst_q;
        xlen_d    = xlen_q;
        ylen_d    = ylen_q;
        sstr_d    = sstr_q;
        dstr_d    = dstr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        xid_d     = xid_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_vld_i) begin
                    chn_d     = cmd_chn_i;
                    src_d     = cmd_src_addr_i;
                    dst_d     = cmd_dst_addr_i;
                    xlen_d    = cmd_xlen_i;
                    ylen_d    = cmd_ylen_i;
                    sstr_d    = cmd_src_strd_i;
                    dstr_d    = cmd_dst_strd_i;
                    step_d    = 3'd0;
                    err_d     = 1'b0;
                    xid_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR;
                end
            end
            S_WR, S_PUSH_WR: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) state_d = S_WB;
            end
            S_WB: begin
                if (m_bvalid_i) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (m_bresp_i != 2'b00) begin
                        err_d   = 1'b1;
                        xid_d   = '0;
                        state_d = S_RSP;
                    end else if (step_q == 3'd6) begin
                        step_d  = 3'd7;
                        state_d = S_RD_AR;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = (step_q == 3'd5) ? S_PUSH_WR : S_WR;
                    end
                end
            end
            S_RD_AR: begin
                if (m_arready_i) state_d = S_RD_R;
            end
            S_RD_R: begin
                if (m_rvalid_i) begin
                    if (m_rresp_i != 2'b00) begin
                        err_d = 1'b1;
                        xid_d = '0;
                    end else begin
                        xid_d = m_rdata_i[ID_W-1:0];
                    end
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_rdy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Each channel owns a 16-word window inside every CSR bank.
    assign chn_off = M_ADDR_W'(chn_q) << 6;

    always_comb begin
        cmd_rdy_o     = (state_q == S_IDLE);
        rsp_vld_o     = (state_q == S_RSP);
        rsp_err_o     = err_q;
        rsp_xfer_id_o = xid_q;
        m_awid_o      = MST_ID_W'(PUSH_ID);
        m_arid_o      = MST_ID_W'(PUSH_ID);
        m_awlen_o     = 8'd0;
        m_arlen_o     = 8'd0;
        m_wlast_o     = 1'b1;
        m_awvalid_o   = wr_st && !aw_done_q;
        m_wvalid_o    = wr_st && !w_done_q;
        m_bready_o    = (state_q == S_WB);
        m_arvalid_o   = (state_q == S_RD_AR);
        m_rready_o    = (state_q == S_RD_R);
        m_araddr_o    = M_ADDR_W'(DMA_BASE_ADDR) + M_ADDR_W'(32'h2004) + chn_off;
        if (step_q == 3'd6)
            m_awaddr_o = M_ADDR_W'(DMA_BASE_ADDR) + M_ADDR_W'(32'h1000) + chn_off;
        else
            m_awaddr_o = M_ADDR_W'(DMA_BASE_ADDR) + chn_off
                       + ((M_ADDR_W'(step_q) + M_ADDR_W'(9)) << 2);
        case (step_q)
            3'd0:    m_wdata_o = M_DATA_W'(src_q);
            3'd1:    m_wdata_o = M_DATA_W'(dst_q);
            3'd2:    m_wdata_o = M_DATA_W'(xlen_q);
            3'd3:    m_wdata_o = M_DATA_W'(ylen_q);
            3'd4:    m_wdata_o = M_DATA_W'(sstr_q);
            3'd5:    m_wdata_o = M_DATA_W'(dstr_q);
            3'd6:    m_wdata_o = M_DATA_W'(1);
            default: m_wdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_adma_desc_pusher.sv
// Directed bench for adma_desc_pusher with a small reactive AXI slave.
module tb_adma_desc_pusher;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [1:0]  cmd_chn = '0;
    logic [31:0] cmd_src = '0, cmd_dst = '0;
    logic [15:0] cmd_xlen = '0, cmd_ylen = '0, cmd_ss = '0, cmd_ds = '0;
    logic        rsp_vld, rsp_rdy = 1'b0, rsp_err;
    logic [1:0]  rsp_xid;
    logic [4:0]  awid, arid;
    logic [31:0] awaddr, araddr, wdata;
    logic [7:0]  awlen, arlen;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic        awrdy, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int checks = 0, failures = 0;
    int aw_delay = 0, err_idx = -1, aw_wait;
    logic [31:0] xfer_val = 32'd0;
    logic        got_aw, got_w;
    logic [31:0] aw_a, w_d, rd_addr;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    int nwr, naw, nw, nrd, split_cnt;
    int stab_viol = 0;
    logic pend = 1'b0;
    logic [31:0] paddr = '0;

    always #5 aclk = ~aclk;

    adma_desc_pusher dut (
        .aclk(aclk), .areset(areset),
        .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy), .cmd_chn_i(cmd_chn),
        .cmd_src_addr_i(cmd_src), .cmd_dst_addr_i(cmd_dst),
        .cmd_xlen_i(cmd_xlen), .cmd_ylen_i(cmd_ylen),
        .cmd_src_strd_i(cmd_ss), .cmd_dst_strd_i(cmd_ds),
        .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy), .rsp_err_o(rsp_err),
        .rsp_xfer_id_o(rsp_xid),
        .m_awid_o(awid), .m_awaddr_o(awaddr), .m_awlen_o(awlen),
        .m_awvalid_o(awvalid), .m_awready_i(awrdy),
        .m_wdata_o(wdata), .m_wlast_o(wlast), .m_wvalid_o(wvalid),
        .m_wready_i(1'b1),
        .m_bid_i(5'd0), .m_bresp_i(bresp), .m_bvalid_i(bvalid),
        .m_bready_o(bready),
        .m_arid_o(arid), .m_araddr_o(araddr), .m_arlen_o(arlen),
        .m_arvalid_o(arvalid), .m_arready_i(1'b1),
        .m_rid_i(5'd0), .m_rdata_i(rdata), .m_rresp_i(rresp),
        .m_rlast_i(1'b1), .m_rvalid_i(rvalid), .m_rready_o(rready)
    );

    // Slave: wready/arready tied high, awready optionally delayed,
    // B and R returned one cycle after the request completes.
    always @(posedge aclk) begin
        if (areset) begin
            awrdy <= (aw_delay == 0); aw_wait <= 0;
            got_aw <= 1'b0; got_w <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
            nwr <= 0; naw <= 0; nw <= 0; nrd <= 0; split_cnt <= 0;
            rd_addr <= '0;
        end else begin
            if (got_aw && got_w) begin
                got_aw <= 1'b0; got_w <= 1'b0;
                bvalid <= 1'b1;
                bresp  <= (nwr == err_idx) ? 2'b10 : 2'b00;
                if (nwr < 16) begin
                    wr_addr[nwr] <= aw_a;
                    wr_data[nwr] <= w_d;
                end
                nwr <= nwr + 1;
            end
            if (awvalid && awrdy) begin
                got_aw <= 1'b1; aw_a <= awaddr; naw <= naw + 1;
                awrdy <= (aw_delay == 0); aw_wait <= 0;
            end else if (awvalid && !awrdy) begin
                if (aw_wait >= aw_delay - 1) awrdy <= 1'b1;
                else aw_wait <= aw_wait + 1;
            end
            if (wvalid) begin
                got_w <= 1'b1; w_d <= wdata; nw <= nw + 1;
            end
            if (awvalid && !wvalid) split_cnt <= split_cnt + 1;
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid) begin
                rd_addr <= araddr; nrd <= nrd + 1;
                rvalid <= 1'b1; rdata <= xfer_val; rresp <= 2'b00;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // Address must not move or drop while AW waits for ready.
    always @(posedge aclk) begin
        if (areset) pend <= 1'b0;
        else begin
            if (pend && (!awvalid || awaddr != paddr)) stab_viol <= stab_viol + 1;
            pend  <= awvalid && !awrdy;
            paddr <= awaddr;
        end
    end

    task automatic do_reset();
        @(negedge aclk); areset = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk); areset = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] c, input logic [31:0] s,
                            input logic [31:0] d, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] ss,
                            input logic [15:0] ds);
        @(negedge aclk);
        cmd_vld = 1'b1; cmd_chn = c; cmd_src = s; cmd_dst = d;
        cmd_xlen = x; cmd_ylen = y; cmd_ss = ss; cmd_ds = ds;
        checks++;
        if (cmd_rdy !== 1'b1) begin
            failures++; $display("FAIL cmd_rdy_idle got=%b exp=1", cmd_rdy);
        end
        @(posedge aclk); #1;
        cmd_vld = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        bit ok = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge aclk);
            if (rsp_vld) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_rsp_timeout got=0 exp=1", tag); end
    endtask

    task automatic finish_rsp(input string tag);
        rsp_rdy = 1'b1;
        checks++;
        if (cmd_rdy !== 1'b0) begin
            failures++; $display("FAIL %s_cmd_rdy_in_hs got=%b exp=0", tag, cmd_rdy);
        end
        @(posedge aclk); #1; rsp_rdy = 1'b0;
        @(negedge aclk);
        checks++;
        if ({rsp_vld, cmd_rdy} !== 2'b01) begin
            failures++; $display("FAIL %s_after_hs got=%b exp=01", tag, {rsp_vld, cmd_rdy});
        end
    endtask

    task automatic test_reset();
        aw_delay = 0; err_idx = -1;
        do_reset();
        checks++;
        if ({cmd_rdy, rsp_vld, awvalid, wvalid, arvalid, bready, rready} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=1000000",
                     {cmd_rdy, rsp_vld, awvalid, wvalid, arvalid, bready, rready});
        end
        checks++;
        if ({rsp_err, rsp_xid} !== 3'b000) begin
            failures++; $display("FAIL reset_rsp got=%b exp=000", {rsp_err, rsp_xid});
        end
    endtask

    task automatic test_nominal();
        logic [31:0] ea [7];
        logic [31:0] ed [7];
        ea = '{32'h8000_00A4, 32'h8000_00A8, 32'h8000_00AC, 32'h8000_00B0,
               32'h8000_00B4, 32'h8000_00B8, 32'h8000_1080};
        ed = '{32'h1000_0000, 32'h2000_0000, 32'h40, 32'h3,
               32'h100, 32'h200, 32'h1};
        aw_delay = 0; err_idx = -1; xfer_val = 32'hFFFF_FFF3;
        do_reset();
        send_cmd(2'd2, 32'h1000_0000, 32'h2000_0000, 16'h40, 16'h3, 16'h100, 16'h200);
        wait_rsp("nom");
        checks++;
        if (nwr !== 7) begin failures++; $display("FAIL nom_nwr got=%0d exp=7", nwr); end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (wr_addr[k] !== ea[k] || wr_data[k] !== ed[k]) begin
                failures++;
                $display("FAIL nom_wr%0d got=%h/%h exp=%h/%h", k, wr_addr[k], wr_data[k], ea[k], ed[k]);
            end
        end
        checks++;
        if (nrd !== 1 || rd_addr !== 32'h8000_2084) begin
            failures++; $display("FAIL nom_rd got=%0d/%h exp=1/80002084", nrd, rd_addr);
        end
        checks++;
        if ({rsp_err, rsp_xid} !== 3'b011) begin
            failures++; $display("FAIL nom_rsp got=%b exp=011", {rsp_err, rsp_xid});
        end
        finish_rsp("nom");
    endtask

    task automatic test_staggered();
        int sv0;
        aw_delay = 3; err_idx = -1; xfer_val = 32'd2;
        do_reset();
        sv0 = stab_viol;
        send_cmd(2'd1, 32'hAAAA_0000, 32'hBBBB_0000, 16'h10, 16'h20, 16'h30, 16'h40);
        wait_rsp("stg");
        checks++;
        if (nwr !== 7 || naw !== 7 || nw !== 7) begin
            failures++; $display("FAIL stg_counts got=%0d/%0d/%0d exp=7/7/7", nwr, naw, nw);
        end
        checks++;
        if (wr_addr[0] !== 32'h8000_0064 || wr_data[0] !== 32'hAAAA_0000) begin
            failures++; $display("FAIL stg_wr0 got=%h/%h exp=80000064/aaaa0000", wr_addr[0], wr_data[0]);
        end
        checks++;
        if (wr_addr[5] !== 32'h8000_0078 || wr_data[5] !== 32'h40) begin
            failures++; $display("FAIL stg_wr5 got=%h/%h exp=80000078/40", wr_addr[5], wr_data[5]);
        end
        checks++;
        if (wr_addr[6] !== 32'h8000_1040 || rd_addr !== 32'h8000_2044) begin
            failures++; $display("FAIL stg_push_rd got=%h/%h exp=80001040/80002044", wr_addr[6], rd_addr);
        end
        checks++;
        if (stab_viol !== sv0) begin
            failures++; $display("FAIL stg_aw_stable got=%0d exp=%0d", stab_viol, sv0);
        end
        checks++;
        if (split_cnt < 7) begin
            failures++; $display("FAIL stg_w_drop got=%0d exp>=7", split_cnt);
        end
        checks++;
        if ({rsp_err, rsp_xid} !== 3'b010) begin
            failures++; $display("FAIL stg_rsp got=%b exp=010", {rsp_err, rsp_xid});
        end
        finish_rsp("stg");
    endtask

    task automatic test_error();
        aw_delay = 0; err_idx = 2; xfer_val = 32'd3;
        do_reset();
        send_cmd(2'd0, 32'h1, 32'h2, 16'h3, 16'h4, 16'h5, 16'h6);
        wait_rsp("err");
        repeat (3) @(negedge aclk);
        checks++;
        if (nwr !== 3 || naw !== 3 || nrd !== 0) begin
            failures++; $display("FAIL err_counts got=%0d/%0d/%0d exp=3/3/0", nwr, naw, nrd);
        end
        checks++;
        if ({rsp_vld, rsp_err, rsp_xid} !== 4'b1100) begin
            failures++; $display("FAIL err_rsp got=%b exp=1100", {rsp_vld, rsp_err, rsp_xid});
        end
        finish_rsp("err");
    endtask

    task automatic test_backpressure();
        aw_delay = 0; err_idx = -1; xfer_val = 32'd1;
        do_reset();
        send_cmd(2'd3, 32'h5, 32'h6, 16'h7, 16'h8, 16'h9, 16'hA);
        wait_rsp("bp");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_vld, rsp_err, rsp_xid, cmd_rdy} !== 5'b10010) begin
                failures++;
                $display("FAIL bp_hold%0d got=%b exp=10010", i, {rsp_vld, rsp_err, rsp_xid, cmd_rdy});
            end
            @(negedge aclk);
        end
        finish_rsp("bp");
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        aw_delay = 0; err_idx = -1; xfer_val = 32'd1;
        do_reset();
        send_cmd(2'd0, 32'h11, 32'h22, 16'h33, 16'h44, 16'h55, 16'h66);
        for (int n = 0; n < 100; n++) begin
            @(negedge aclk);
            if (bready) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL rm_wb_timeout got=0 exp=1"); end
        areset = 1'b1;
        @(negedge aclk);
        checks++;
        if ({cmd_rdy, awvalid, wvalid, arvalid, bready, rready, rsp_vld} !== 7'b1000000) begin
            failures++;
            $display("FAIL rm_after_rst got=%b exp=1000000",
                     {cmd_rdy, awvalid, wvalid, arvalid, bready, rready, rsp_vld});
        end
        areset = 1'b0;
        send_cmd(2'd3, 32'hCAFE_0000, 32'hBEEF_0000, 16'h1, 16'h2, 16'h3, 16'h4);
        wait_rsp("rm");
        checks++;
        if (nwr !== 7 || wr_addr[0] !== 32'h8000_00E4 || wr_addr[6] !== 32'h8000_10C0) begin
            failures++;
            $display("FAIL rm_writes got=%0d/%h/%h exp=7/800000e4/800010c0", nwr, wr_addr[0], wr_addr[6]);
        end
        checks++;
        if (rd_addr !== 32'h8000_20C4 || {rsp_err, rsp_xid} !== 3'b001) begin
            failures++; $display("FAIL rm_rsp got=%h/%b exp=800020c4/001", rd_addr, {rsp_err, rsp_xid});
        end
        finish_rsp("rm");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_staggered();
        test_error();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
